// File: rtl/ft_recovery_ctrl.sv
// ============================================================================
// ft_recovery_ctrl : DMR/TMR lockstep divergence detector with shadow-regfile
//                    based halt / rewrite / resume recovery.
// Optional: FT_ERR_COUNTER_EN builds the saturating divergence counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ft_recovery_ctrl #(
  parameter int NCORES       = 2,
  parameter int NREGS        = 32,
  parameter int HALT_TIMEOUT = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NCORES-1:0]      we_i,
  input  logic [NCORES*5-1:0]    waddr_i,
  input  logic [NCORES*32-1:0]   wdata_i,
  input  logic [31:0]            spc_i,
  input  logic [NCORES-1:0]      halted_i,
  output logic                   halt_o,
  output logic                   resume_o,
  output logic                   dbg_we_o,
  output logic [14:0]            dbg_addr_o,
  output logic [31:0]            dbg_wdata_o,
  output logic                   core_rst_o,
  output logic                   busy_o,
  output logic [15:0]            err_count_o
);

  localparam int        IW     = $clog2(NREGS);
  localparam int        CW     = $clog2(HALT_TIMEOUT + 1);
  localparam logic [5:0] NREGS6 = 6'(NREGS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HALT   = 3'd1,
    S_WREG   = 3'd2,
    S_WPC    = 3'd3,
    S_RESUME = 3'd4,
    S_RESET  = 3'd5
  } state_t;

  // Tuple layout: {we, waddr[4:0], wdata[31:0]}
  logic [NCORES-1:0][37:0] tup;
  logic                    diverge;
  logic                    vote_ok;
  logic                    fatal;
  logic [37:0]             voted;

  for (genvar c = 0; c < NCORES; c++) begin : g_tup
    assign tup[c] = {we_i[c], waddr_i[c*5 +: 5], wdata_i[c*32 +: 32]};
  end

  if (NCORES == 3) begin : g_tmr
    logic eq01, eq02, eq12;
    assign eq01    = (tup[0] == tup[1]);
    assign eq02    = (tup[0] == tup[2]);
    assign eq12    = (tup[1] == tup[2]);
    assign vote_ok = eq01 | eq02 | eq12;
    assign diverge = !(eq01 && eq12);
    assign fatal   = !vote_ok;
    assign voted   = (eq01 || eq02) ? tup[0] : tup[1];
  end else begin : g_dmr
    assign vote_ok = (tup[0] == tup[1]);
    assign diverge = !vote_ok;
    assign fatal   = 1'b0;
    assign voted   = tup[0];
  end

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     last_pc_q, last_pc_d;
  logic [31:0]     shadow_q [1:NREGS-1];
  logic [31:0]     shadow_d [1:NREGS-1];
  logic            wr_en;
  logic [31:0]     rd_data;

  // Only IDLE commits; a TMR majority is committed even while diverging.
  assign wr_en = (state_q == S_IDLE) && vote_ok && voted[37] &&
                 (voted[36:32] != 5'd0) && ({1'b0, voted[36:32]} < NREGS6);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    last_pc_d   = last_pc_q;
    shadow_d    = shadow_q;
    rd_data     = 32'd0;
    halt_o      = 1'b0;
    resume_o    = 1'b0;
    dbg_we_o    = 1'b0;
    dbg_addr_o  = 15'd0;
    dbg_wdata_o = 32'd0;
    core_rst_o  = 1'b0;
    busy_o      = (state_q != S_IDLE);

    for (int i = 1; i < NREGS; i++) begin
      if (state_q == S_RESET) begin
        shadow_d[i] = 32'd0;
      end else if (wr_en && (voted[36:32] == 5'(i))) begin
        shadow_d[i] = voted[31:0];
      end
      if (idx_q == IW'(i)) begin
        rd_data = shadow_q[i];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (diverge) begin
          cnt_d   = '0;
          state_d = fatal ? S_RESET : S_HALT;
        end else begin
          last_pc_d = spc_i;
        end
      end
      S_HALT: begin
        halt_o = 1'b1;
        if (&halted_i) begin
          idx_d   = IW'(1);
          state_d = S_WREG;
        end else if (cnt_q == CW'(HALT_TIMEOUT - 1)) begin
          cnt_d   = '0;
          state_d = S_RESET;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_WREG: begin
        halt_o      = 1'b1;
        dbg_we_o    = 1'b1;
        dbg_addr_o  = 15'h400 + 15'(idx_q);
        dbg_wdata_o = rd_data;
        if (idx_q == IW'(NREGS - 1)) begin
          state_d = S_WPC;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_WPC: begin
        halt_o      = 1'b1;
        dbg_we_o    = 1'b1;
        dbg_addr_o  = 15'h2000;
        dbg_wdata_o = last_pc_q;
        state_d     = S_RESUME;
      end
      S_RESUME: begin
        resume_o = 1'b1;
        idx_d    = '0;
        state_d  = S_IDLE;
      end
      S_RESET: begin
        core_rst_o = 1'b1;
        last_pc_d  = 32'd0;
        if (cnt_q == CW'(1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      last_pc_q <= 32'd0;
      for (int i = 1; i < NREGS; i++) begin
        shadow_q[i] <= 32'd0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      last_pc_q <= last_pc_d;
      shadow_q  <= shadow_d;
    end
  end

`ifdef FT_ERR_COUNTER_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((state_q == S_IDLE) && diverge && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count_o = err_cnt_q;
`else
  assign err_count_o = 16'd0;
`endif

endmodule

`default_nettype wire

// File: doc/ft_recovery_ctrl.md
# ft_recovery_ctrl

Parametrised fault-tolerance controller for N-way lockstep zeroriscy clusters with 2 (DMR) or 3 (TMR) cores. It compares every core's register-file write port each cycle and keeps a shadow register file of agreed values plus a last-good PC. On divergence it halts all cores through the debug interface, rewrites their register files and PC from the shadow copy, then resumes them. It sits beside the cores in the fault-tolerant core wrapper and drives the shared debug halt/resume/write buses.

## Interface
- NCORES, 2, number of redundant cores; legal values 2 or 3.
- NREGS, 32, architectural registers: 32 for RV32I, 16 for RV32E.
- HALT_TIMEOUT, 64, maximum cycles to wait for all cores to halt.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- we_i  in  NCORES  per-core regfile write enable.
- waddr_i  in  NCORES×5  per-core write address, packed, core 0 in the LSBs.
- wdata_i  in  NCORES×32  per-core write data, packed.
- spc_i  in  32  core-0 fetch PC.
- halted_i  in  NCORES  per-core debug_halted.
- halt_o  out  1  debug halt request to all cores.
- resume_o  out  1  debug resume pulse to all cores.
- dbg_we_o  out  1  debug write strobe.
- dbg_addr_o  out  15  debug address.
- dbg_wdata_o  out  32  debug write data.
- core_rst_o  out  1  active-high core reset request.
- busy_o  out  1  recovery in progress (state ≠ IDLE).
- err_count_o  out  16  detected divergence count.

## Operation
- Agreement: core write tuples {we, waddr, wdata} are compared. DMR: agree iff both are equal. TMR: majority exists iff at least two are equal. The agreed or majority tuple is the voted tuple.
- Shadow file: NREGS×32 registers, reset to 0. On a voted tuple with we=1 and waddr≠0, write it at the next clock edge. Writes with waddr≥NREGS are ignored. x0 is never stored.
- last_pc: register, reset 0. Loads spc_i each IDLE cycle with no divergence. Frozen otherwise.
- Divergence: any inequality among tuples in IDLE. DMR divergence, or TMR divergence with a majority, goes to HALT. TMR with all three different goes to RESET.
- FSM states:
  - IDLE: watch for divergence.
  - HALT: halt_o=1. When &halted_i, go to WREG with idx=1. If the wait counter reaches HALT_TIMEOUT, go to RESET.
  - WREG: halt_o=1, dbg_we_o=1, dbg_addr_o=15'h400+idx, dbg_wdata_o=shadow[idx]. idx increments each cycle. After idx=NREGS-1, go to WPC.
  - WPC: halt_o=1, dbg_we_o=1, dbg_addr_o=15'h2000, dbg_wdata_o=last_pc. Go to RESUME.
  - RESUME: resume_o=1 for exactly one cycle, halt_o=0. Go to IDLE.
  - RESET: core_rst_o=1 for 2 cycles. Shadow file and last_pc cleared. Go to IDLE.
- Comparison is ignored outside IDLE; core writes during recovery never update the shadow file.
- A divergence in the same cycle as a voted write (TMR): the majority value is still committed to the shadow file.

## Timing
- Reset values: all outputs 0, state IDLE, idx 0, counters 0.
- Divergence sampled at cycle t gives state=HALT and halt_o=1 at t+1.
- halted_i all high at cycle h gives the first WREG write at h+1.
- Recovery length after halt: NREGS-1 WREG cycles + 1 WPC cycle + 1 RESUME cycle.
- In all non-write states dbg_we_o=0, dbg_addr_o=0, dbg_wdata_o=0.
- rst_i during recovery: immediately IDLE, all outputs 0, shadow cleared.
- halted_i dropping during WREG/WPC is ignored; the sequence completes.

## Configuration
- FT_ERR_COUNTER_EN defined: err_count_o is a saturating 16-bit counter. It increments on every IDLE→HALT or IDLE→RESET transition, holds at 16'hFFFF, and is cleared only by rst_i.
- FT_ERR_COUNTER_EN undefined: err_count_o tied to 0 and no counter logic is built.

## Test plan
- DMR agreement: both cores write x5=32'hDEAD_BEEF -> shadow[5]=32'hDEAD_BEEF; halt_o stays 0; err_count_o=0.
- DMR mismatch: core0 x3=1, core1 x3=2 at t, spc_i=32'h80 -> halt_o=1 at t+1. After halted_i=2'b11, 31 writes at 15'h401..15'h41F, then 15'h2000 with 32'h80, then one resume_o pulse; err_count_o=1.
- TMR single fault: cores write x7=5,5,9 -> shadow[7]=5; recovery rewrites 15'h407 with 5.
- TMR triple disagreement: x1=1,2,3 -> core_rst_o=1 for 2 cycles, shadow cleared, no halt_o.
- Halt timeout: HALT_TIMEOUT=64 with halted_i stuck at 2'b01 -> RESET entered 64 cycles after halt_o rises.
- Mid-recovery reset: rst_i asserted during WREG idx=10 -> all outputs 0 immediately; IDLE on release; with NREGS=16, recovery writes only 15'h401..15'h40F.
